axis_master_port: RTL

Output stage of the resizer, directly downstream of the entry buffer. It pops M_KEEP_WIDTH-lane entries from the buffer and drives them onto the master AXI-Stream port. It holds a two-deep skid (output register plus skid register), so m_axis_tready never reaches the buffer combinationally. It drops null entries, checks lane ordering around tlast, and counts beats and packets.

---
 rtl/resizer_pkg.sv | 33 +++
 rtl/entry_unpack.sv | 60 ++++++
 rtl/axis_master_port.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/resizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resizer_pkg
// Description : Shared definitions for the AXI-Stream resizer. Holds the
//               buffer-side lane layout {last, keep, data} so the entry
//               buffer and the master port agree on bit positions, plus the
//               master-port state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package resizer_pkg;

    // Data bits carried by one lane.
    localparam int LANE_DATA_W = 1;

    // Lane field offsets, with data occupying the LSBs.
    localparam int KEEP_BIT    = LANE_DATA_W;
    localparam int LAST_BIT    = LANE_DATA_W + 1;
    localparam int LANE_W      = LANE_DATA_W + 2;

    typedef struct packed {
        logic                   last;
        logic                   keep;
        logic [LANE_DATA_W-1:0] data;
    } lane_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } st_e;

endpackage : resizer_pkg
`default_nettype wire

// File: rtl/entry_unpack.sv
`default_nettype none
// ============================================================================
// Module      : entry_unpack
// Description : Combinational decode of one buffer entry into beat fields.
//   entry     in  : M_KEEP_WIDTH lanes, lane 0 in the LSBs
//   tdata     out : concatenated lane data, lane 0 least significant
//   tkeep     out : lane keep bits
//   tlast     out : OR of lane last bits
//   is_null   out : no keep and no last -> entry carries nothing
//   order_err out : some lane above a last-lane still has keep set
// Revision    : 1.0 - initial release
// ============================================================================
module entry_unpack
    import resizer_pkg::*;
#(
    parameter int T_DATA_WIDTH = LANE_DATA_W,
    parameter int M_KEEP_WIDTH = 2,
    parameter int LANE_SZ      = T_DATA_WIDTH + 2,
    parameter int ENTRY_SZ     = LANE_SZ * M_KEEP_WIDTH
) (
    input  logic [ENTRY_SZ-1:0]                  entry,
    output logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] tdata,
    output logic [M_KEEP_WIDTH-1:0]              tkeep,
    output logic                                 tlast,
    output logic                                 is_null,
    output logic                                 order_err
);

    lane_t w_lane;
    logic  w_seen_last;

    always_comb begin
        tdata       = '0;
        tkeep       = '0;
        tlast       = 1'b0;
        order_err   = 1'b0;
        w_seen_last = 1'b0;
        w_lane      = '0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            w_lane.last = entry[i*LANE_SZ + LAST_BIT];
            w_lane.keep = entry[i*LANE_SZ + KEEP_BIT];
            w_lane.data = entry[i*LANE_SZ +: LANE_DATA_W];

            tdata[i*T_DATA_WIDTH +: T_DATA_WIDTH] = w_lane.data;
            tkeep[i] = w_lane.keep;

            // A kept lane after a lane that already closed the packet.
            if (w_seen_last && w_lane.keep) begin
                order_err = 1'b1;
            end
            if (w_lane.last) begin
                w_seen_last = 1'b1;
                tlast       = 1'b1;
            end
        end
        is_null = ~(|tkeep) && !tlast;
    end

endmodule : entry_unpack
`default_nettype wire

// File: rtl/axis_master_port.sv
`default_nettype none
// ============================================================================
// Module      : axis_master_port
// Description : Resizer output stage. Pops entries from the show-ahead entry
//               buffer and drives the master AXI-Stream port through an
//               output register backed by a skid register, so tready never
//               reaches the buffer combinationally. Null entries are dropped,
//               lane ordering around tlast is checked, beats/packets counted.
//   clk, rst              : clock, synchronous active-high reset
//   entry_i/entry_empty_i : buffer head entry and its empty flag
//   entry_ready_o         : pop request (registered-state decode only)
//   m_axis_*              : master AXI-Stream beat
//   beat_cnt_o/pkt_cnt_o  : wrapping handshake / tlast-handshake counters
//   proto_err_o           : sticky lane-order error
// Revision    : 1.0 - initial release
// ============================================================================
module axis_master_port
    import resizer_pkg::*;
#(
    parameter int T_DATA_WIDTH = LANE_DATA_W,
    parameter int M_KEEP_WIDTH = 2,
    parameter int LANE_SZ      = T_DATA_WIDTH + 2,
    parameter int ENTRY_SZ     = LANE_SZ * M_KEEP_WIDTH,
    parameter int CNT_W        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ENTRY_SZ-1:0]                  entry_i,
    input  logic                                 entry_empty_i,
    output logic                                 entry_ready_o,
    output logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0]              m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [CNT_W-1:0]                     beat_cnt_o,
    output logic [CNT_W-1:0]                     pkt_cnt_o,
    output logic                                 proto_err_o
);

    localparam int DW = T_DATA_WIDTH * M_KEEP_WIDTH;

    st_e                    r_state;
    st_e                    w_next_state;

    logic [DW-1:0]           r_out_data;
    logic [M_KEEP_WIDTH-1:0] r_out_keep;
    logic                    r_out_last;
    logic [DW-1:0]           r_skid_data;
    logic [M_KEEP_WIDTH-1:0] r_skid_keep;
    logic                    r_skid_last;

    logic [CNT_W-1:0]        r_beat_cnt;
    logic [CNT_W-1:0]        r_pkt_cnt;
    logic                    r_proto_err;

    logic [DW-1:0]           w_ent_data;
    logic [M_KEEP_WIDTH-1:0] w_ent_keep;
    logic                    w_ent_last;
    logic                    w_ent_null;
    logic                    w_ent_order_err;

    logic                    w_pop;
    logic                    w_pop_real;
    logic                    w_hs;
    logic                    w_load_out_entry;
    logic                    w_load_out_skid;
    logic                    w_load_skid;

    entry_unpack #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .M_KEEP_WIDTH (M_KEEP_WIDTH),
        .LANE_SZ      (LANE_SZ),
        .ENTRY_SZ     (ENTRY_SZ)
    ) u_unpack (
        .entry     (entry_i),
        .tdata     (w_ent_data),
        .tkeep     (w_ent_keep),
        .tlast     (w_ent_last),
        .is_null   (w_ent_null),
        .order_err (w_ent_order_err)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_pop_real) begin
                    w_next_state = ST_ONE;
                end
            end
            ST_ONE: begin
                if (m_axis_tready) begin
                    if (!w_pop_real) begin
                        w_next_state = ST_EMPTY;
                    end
                end else if (w_pop_real) begin
                    w_next_state = ST_TWO;
                end
            end
            ST_TWO: begin
                if (m_axis_tready) begin
                    w_next_state = ST_ONE;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Both decode registered state only; rst gates the pop request so the
    // buffer is never drained while the port is being flushed.
    always_comb begin
        m_axis_tvalid = (r_state == ST_ONE) || (r_state == ST_TWO);
        entry_ready_o = (r_state != ST_TWO) && !rst;
    end

    // ---------------- datapath control ----------------
    assign w_pop      = entry_ready_o && !entry_empty_i;
    assign w_pop_real = w_pop && !w_ent_null;
    assign w_hs       = m_axis_tvalid && m_axis_tready;

    always_comb begin
        w_load_out_entry = 1'b0;
        w_load_out_skid  = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: w_load_out_entry = w_pop_real;
            ST_ONE: begin
                w_load_out_entry = w_pop_real && m_axis_tready;
                w_load_skid      = w_pop_real && !m_axis_tready;
            end
            ST_TWO:   w_load_out_skid = m_axis_tready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_keep <= '0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_load_out_entry) begin
                r_out_data <= w_ent_data;
                r_out_keep <= w_ent_keep;
                r_out_last <= w_ent_last;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_keep <= r_skid_keep;
                r_out_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= w_ent_data;
                r_skid_keep <= w_ent_keep;
                r_skid_last <= w_ent_last;
            end
        end
    end

    // ---------------- counters and error flag ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (r_out_last) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                end
            end
            if (w_pop && w_ent_order_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign m_axis_tdata = r_out_data;
    assign m_axis_tkeep = r_out_keep;
    assign m_axis_tlast = r_out_last;
    assign beat_cnt_o   = r_beat_cnt;
    assign pkt_cnt_o    = r_pkt_cnt;
    assign proto_err_o  = r_proto_err;

endmodule : axis_master_port
`default_nettype wire
